// File: rtl/i2c_config_sequencer.sv
// Single-owner sequencer for the I2C register-access engine: replays the init
// ROM, polls HPD periodically and serves host accesses, one access at a time.
module i2c_config_sequencer #(
  parameter logic [6:0] CHIP_ADDR     = 7'h39,
  parameter int         INIT_LEN      = 16,
  parameter int         AW            = 5,
  parameter int         POLL_INTERVAL = 1000000,
  parameter logic [7:0] HPD_REG       = 8'h42,
  parameter int         HPD_BIT       = 6,
  parameter int         TIMEOUT       = 1048575
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          ext_req,
  input  logic          ext_is_read,
  input  logic [7:0]    ext_reg,
  input  logic [7:0]    ext_value,
  output logic          ext_ack,
  output logic [7:0]    ext_data,
  output logic          hpd,
  output logic          init_done,
  output logic          timeout_err,
  output logic [6:0]    cfg_chip_addr,
  output logic [7:0]    cfg_reg_addr,
  output logic [7:0]    cfg_value,
  output logic          cfg_is_read,
  output logic          cfg_enable,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_done
);

  localparam logic [2:0] S_INIT_FETCH = 3'd0;
  localparam logic [2:0] S_INIT_ISSUE = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT_LOW   = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH  = 3'd5;
  localparam logic [2:0] S_COMPLETE   = 3'd6;

  localparam logic [1:0] K_INIT = 2'd0;
  localparam logic [1:0] K_EXT  = 2'd1;
  localparam logic [1:0] K_POLL = 2'd2;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [23:0]   POLL_MAX = 24'(POLL_INTERVAL - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(INIT_LEN - 1);

  logic [2:0]    state;
  logic [1:0]    kind;
  logic [23:0]   poll_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_hi_seen;
  logic          restart_pend;
  logic          poll_due;
  logic          new_hpd;
  logic          restart_any;

  assign cfg_chip_addr = CHIP_ADDR;
  assign poll_due      = (poll_cnt == POLL_MAX);
  assign new_hpd       = cfg_data[HPD_BIT];
  assign restart_any   = restart | restart_pend;

  // rom_addr doubles as the init-table index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_INIT_FETCH;
      kind         <= K_INIT;
      poll_cnt     <= '0;
      to_cnt       <= '0;
      done_hi_seen <= 1'b0;
      restart_pend <= 1'b0;
      rom_addr     <= '0;
      ext_ack      <= 1'b0;
      ext_data     <= '0;
      hpd          <= 1'b0;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
      cfg_reg_addr <= '0;
      cfg_value    <= '0;
      cfg_is_read  <= 1'b0;
      cfg_enable   <= 1'b0;
    end else begin
      cfg_enable <= 1'b0;
      ext_ack    <= 1'b0;
      if (!poll_due) poll_cnt <= poll_cnt + 24'd1;
      if (restart && state != S_IDLE) restart_pend <= 1'b1;

      case (state)
        S_INIT_FETCH: state <= S_INIT_ISSUE;
        S_INIT_ISSUE: begin
          cfg_reg_addr <= rom_data[15:8];
          cfg_value    <= rom_data[7:0];
          cfg_is_read  <= 1'b0;
          kind         <= K_INIT;
          state        <= S_ISSUE;
        end
        S_IDLE: begin
          if (restart_any) begin
            restart_pend <= 1'b0;
            init_done    <= 1'b0;
            rom_addr     <= '0;
            state        <= S_INIT_FETCH;
          end else if (ext_req) begin
            cfg_reg_addr <= ext_reg;
            cfg_value    <= ext_value;
            cfg_is_read  <= ext_is_read;
            kind         <= K_EXT;
            state        <= S_ISSUE;
          end else if (poll_due) begin
            poll_cnt     <= '0;
            cfg_reg_addr <= HPD_REG;
            cfg_value    <= '0;
            cfg_is_read  <= 1'b1;
            kind         <= K_POLL;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt       <= '0;
          done_hi_seen <= 1'b0;
          if (cfg_done) begin
            cfg_enable <= 1'b1;
            state      <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW, S_WAIT_HIGH: begin
          // Timeout only flags the stall; the engine cannot be aborted.
          if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            to_cnt      <= TO_MAX;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (state == S_WAIT_HIGH) begin
            if (cfg_done) state <= S_COMPLETE;
          end else if (!cfg_enable) begin
            // Two done-high cycles after the pulse: engine finished unseen.
            if (!cfg_done)         state <= S_WAIT_HIGH;
            else if (done_hi_seen) state <= S_COMPLETE;
            else                   done_hi_seen <= 1'b1;
          end
        end
        S_COMPLETE: begin
          case (kind)
            K_INIT: begin
              rom_addr <= rom_addr + 1'b1;
              if (rom_addr == LAST_IDX) begin
                init_done <= 1'b1;
                state     <= S_IDLE;
              end else begin
                state <= S_INIT_FETCH;
              end
            end
            K_EXT: begin
              ext_data <= cfg_data;
              ext_ack  <= 1'b1;
              state    <= S_IDLE;
            end
            K_POLL: begin
              hpd <= new_hpd;
              if (!hpd && new_hpd) begin
                init_done <= 1'b0;
                rom_addr  <= '0;
                state     <= S_INIT_FETCH;
              end else begin
                state <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural engine/ROM models, directed and
// randomized host accesses checked against a transaction-level expectation.
module tb_i2c_config_sequencer;

  localparam int         INIT_LEN      = 3;
  localparam int         AW            = 5;
  localparam int         POLL_INTERVAL = 100;
  localparam int         TIMEOUT       = 50;
  localparam logic [7:0] HPD_REG       = 8'h42;

  typedef struct packed {
    logic       rd;
    logic [7:0] ra;
    logic [7:0] val;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          restart = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic          ext_req = 1'b0;
  logic          ext_is_read = 1'b0;
  logic [7:0]    ext_reg = 8'h00;
  logic [7:0]    ext_value = 8'h00;
  logic          ext_ack;
  logic [7:0]    ext_data;
  logic          hpd;
  logic          init_done;
  logic          timeout_err;
  logic [6:0]    cfg_chip_addr;
  logic [7:0]    cfg_reg_addr;
  logic [7:0]    cfg_value;
  logic          cfg_is_read;
  logic          cfg_enable;
  logic [7:0]    cfg_data = 8'h00;
  logic          cfg_done = 1'b1;

  i2c_config_sequencer #(
    .CHIP_ADDR(7'h39), .INIT_LEN(INIT_LEN), .AW(AW), .POLL_INTERVAL(POLL_INTERVAL),
    .HPD_REG(HPD_REG), .HPD_BIT(6), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ext_req(ext_req), .ext_is_read(ext_is_read), .ext_reg(ext_reg), .ext_value(ext_value),
    .ext_ack(ext_ack), .ext_data(ext_data),
    .hpd(hpd), .init_done(init_done), .timeout_err(timeout_err),
    .cfg_chip_addr(cfg_chip_addr), .cfg_reg_addr(cfg_reg_addr), .cfg_value(cfg_value),
    .cfg_is_read(cfg_is_read), .cfg_enable(cfg_enable),
    .cfg_data(cfg_data), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  // Synchronous init ROM: data follows the address by one clock.
  logic [15:0] rom [INIT_LEN] = '{16'h4110, 16'h9803, 16'hD6C0};
  always @(posedge clk)
    rom_data <= (int'(rom_addr) < INIT_LEN) ? rom[int'(rom_addr)] : 16'hFFFF;

  // Engine + device model. busy_len=0 means done never drops.
  int         busy_len = 20;
  bit         stuck = 1'b0;
  bit         hpd_line = 1'b0;
  int         eng_cnt = 0;
  acc_t       cur;
  acc_t       en_a;
  acc_t       log_q[$];
  int         n_en = 0;
  int         n_poll_done = 0;
  int         n_wr_done = 0;
  logic [7:0] dev_mem [256];
  bit         dev_vld [256];

  function automatic logic [7:0] eng_exec(input acc_t a);
    logic [7:0] r;
    if (a.rd) begin
      if (a.ra == HPD_REG) begin
        r = hpd_line ? 8'h40 : 8'h00;
        n_poll_done++;
      end else begin
        r = dev_vld[a.ra] ? dev_mem[a.ra] : (a.ra ^ 8'h13);
      end
    end else begin
      dev_mem[a.ra] = a.val;
      dev_vld[a.ra] = 1'b1;
      n_wr_done++;
      r = 8'h00;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      cfg_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (cfg_enable) begin
      en_a = '{rd: cfg_is_read, ra: cfg_reg_addr, val: cfg_value};
      cur <= en_a;
      n_en++;
      if (!(en_a.rd && en_a.ra == HPD_REG)) log_q.push_back(en_a);
      if (busy_len == 0) begin
        cfg_data <= eng_exec(en_a);
      end else begin
        cfg_done <= 1'b0;
        eng_cnt  <= busy_len;
      end
    end else if (!cfg_done && !stuck) begin
      if (eng_cnt <= 1) begin
        cfg_done <= 1'b1;
        cfg_data <= eng_exec(cur);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Protocol monitors, checked from the main sequence.
  int dbl_en = 0;
  int ack_early = 0;
  bit en_prev = 1'b0;
  always @(negedge clk) begin
    if (cfg_enable && en_prev) dbl_en++;
    if (ext_ack && !init_done) ack_early++;
    en_prev = cfg_enable;
  end

  // Expected device contents as seen by the host.
  logic [7:0] exp_mem [256];
  bit         exp_vld [256];

  function automatic logic [7:0] exp_rd(input logic [7:0] ra);
    return exp_vld[ra] ? exp_mem[ra] : (ra ^ 8'h13);
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_outs"},
        32'({cfg_enable, cfg_is_read, cfg_reg_addr, cfg_value, ext_ack, ext_data,
             hpd, init_done, timeout_err}), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_chip"}, 32'(cfg_chip_addr), 32'h39);
  endtask

  task automatic chk_rom_seq(input string tag, input int base);
    chk({tag, "_n"}, 32'(log_q.size() - base >= INIT_LEN), 32'd1);
    for (int i = 0; i < INIT_LEN; i++) begin
      if (base + i < log_q.size())
        chk($sformatf("%s_e%0d", tag, i),
            32'({log_q[base+i].rd, log_q[base+i].ra, log_q[base+i].val}), 32'({1'b0, rom[i]}));
      exp_mem[rom[i][15:8]] = rom[i][7:0];
      exp_vld[rom[i][15:8]] = 1'b1;
    end
  endtask

  task automatic wait_init_done(input string tag);
    bit ok;
    ok = init_done;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = init_done;
    end
    chk({tag, "_init_done"}, 32'(ok), 32'd1);
  endtask

  task automatic do_ext(input logic rd, input logic [7:0] ra, input logic [7:0] val,
                        input string tag);
    int m;
    bit ok;
    m  = log_q.size();
    ok = 1'b0;
    ext_is_read = rd; ext_reg = ra; ext_value = val; ext_req = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ext_ack) begin
        ok = 1'b1;
        break;
      end
    end
    ext_req = 1'b0;
    chk({tag, "_ack"}, 32'(ok), 32'd1);
    if (ok) begin
      if (rd) begin
        chk({tag, "_data"}, 32'(ext_data), 32'(exp_rd(ra)));
      end else begin
        exp_mem[ra] = val;
        exp_vld[ra] = 1'b1;
      end
      chk({tag, "_nacc"}, 32'(log_q.size() - m), 32'd1);
      if (log_q.size() > m) begin
        if (rd) chk({tag, "_acc"}, 32'({log_q[m].rd, log_q[m].ra}), 32'({1'b1, ra}));
        else    chk({tag, "_acc"}, 32'({log_q[m].rd, log_q[m].ra, log_q[m].val}), 32'({1'b0, ra, val}));
      end
      @(negedge clk);
      chk({tag, "_ack_pulse"}, 32'(ext_ack), 32'd0);
    end
  endtask

  int         mark;
  int         en_base;
  int         pbase;
  bit         ok;
  bit         saw_low;
  logic       r_rd;
  logic [7:0] r_ra;
  logic [7:0] r_val;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    // Init table after reset release.
    mark = log_q.size();
    reset = 1'b1;
    wait_init_done("init0");
    chk("init0_wr_count", 32'(n_wr_done), 32'd3);
    chk("init0_en_count", 32'(n_en), 32'd3);
    chk_rom_seq("init0", mark);
    chk("init0_hpd", 32'(hpd), 32'd0);

    // Directed host read, then randomized host traffic.
    do_ext(1'b1, 8'h00, 8'h00, "ext_rd00");
    for (int k = 0; k < 24; k++) begin
      busy_len = int'($urandom_range(0, 30));
      r_rd  = 1'($urandom_range(0, 1));
      r_ra  = ($urandom_range(0, 7) == 0) ? 8'h41 : 8'(8'h10 + 8'($urandom_range(0, 7)));
      r_val = 8'($urandom_range(0, 255));
      do_ext(r_rd, r_ra, r_val, $sformatf("rnd%0d", k));
    end

    // HPD low poll, then rising HPD replays init.
    busy_len = 20;
    pbase = n_poll_done;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (n_poll_done > pbase);
    end
    chk("poll_seen", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    chk("poll_low_hpd", 32'({hpd, init_done}), 32'b01);
    hpd_line = 1'b1;
    mark = log_q.size();
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = hpd;
    end
    chk("hpd_rise", 32'({hpd, init_done}), 32'b10);
    wait_init_done("hpd_reinit");
    chk_rom_seq("hpd_reinit", mark);

    // Restart pulsed in the middle of a host write.
    mark = log_q.size();
    ext_is_read = 1'b0; ext_reg = 8'h17; ext_value = 8'hA5; ext_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = (log_q.size() > mark);
    end
    chk("rst_mid_issue", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = ext_ack;
    end
    ext_req = 1'b0;
    exp_mem[8'h17] = 8'hA5;
    exp_vld[8'h17] = 1'b1;
    chk("rst_mid_ack", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = !init_done;
    end
    chk("rst_mid_reinit_start", 32'(ok), 32'd1);
    wait_init_done("rst_mid");
    chk("rst_mid_first", (log_q.size() > mark) ? 32'(log_q[mark]) : 32'hFFFF_FFFF,
        32'({1'b0, 8'h17, 8'hA5}));
    chk_rom_seq("rst_mid_seq", mark + 1);

    // Restart and host request together: host waits for the init replay.
    mark = log_q.size();
    restart = 1'b1;
    ext_is_read = 1'b1; ext_reg = 8'h41; ext_value = 8'h00; ext_req = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    ok = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!init_done) saw_low = 1'b1;
      ok = ext_ack;
    end
    ext_req = 1'b0;
    chk("sim_ack", 32'(ok), 32'd1);
    chk("sim_ack_after_init", 32'({saw_low, init_done}), 32'b11);
    chk("sim_data", 32'(ext_data), 32'h10);
    chk_rom_seq("sim_seq", mark);
    chk("sim_ext_last", (log_q.size() > mark + 3) ? 32'({log_q[mark+3].rd, log_q[mark+3].ra}) : 32'hFFFF_FFFF,
        32'({1'b1, 8'h41}));

    // Engine never shows busy.
    busy_len = 0;
    do_ext(1'b0, 8'h15, 8'h5A, "missed_wr");
    do_ext(1'b1, 8'h15, 8'h00, "missed_rd");
    chk("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Engine holds done low forever.
    busy_len = 20;
    mark = log_q.size();
    ext_is_read = 1'b0; ext_reg = 8'h16; ext_value = 8'h3C; ext_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = (log_q.size() > mark);
    end
    stuck = 1'b1;
    chk("stuck_issue", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    chk("timeout_early", 32'(timeout_err), 32'd0);
    repeat (15) @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 32'd1);
    en_base = n_en;
    repeat (200) @(negedge clk);
    chk("stuck_no_enable", 32'(n_en - en_base), 32'd0);
    chk("stuck_no_ack", 32'({ext_ack, timeout_err}), 32'b01);

    // Asynchronous reset while waiting for done.
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    ext_req  = 1'b0;
    stuck    = 1'b0;
    hpd_line = 1'b0;
    repeat (2) @(negedge clk);
    mark = log_q.size();
    reset = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (log_q.size() > mark);
    end
    chk("post_reset_first", ok ? 32'(log_q[mark]) : 32'hFFFF_FFFF, 32'({1'b0, rom[0]}));
    wait_init_done("post_reset");
    chk("enable_one_cycle", 32'(dbl_en), 32'd0);
    chk("no_ack_before_init", 32'(ack_early), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
